// File: rtl/feature_rd_arbiter.sv
// Two-requester burst read arbiter in front of a registered-output feature RAM.
// Define FEAT_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 has fixed priority.
module feature_rd_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 128,
  parameter int LEN_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [15:0]       base0,
  input  logic [15:0]       base1,
  input  logic [LEN_W-1:0]  len0,
  input  logic [LEN_W-1:0]  len1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BURST0 = 2'd1;
  localparam logic [1:0] BURST1 = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [1:0]        done_q, done_d;
  logic              any_req, win1, last_beat;

  // Only the low address bits of base reach the RAM.
  logic unused_base_hi;
  assign unused_base_hi = ^{base0[15:ADDR_W], base1[15:ADDR_W]};

  assign any_req   = req0 | req1;
  assign last_beat = (cnt_q == LEN_W'(1));

`ifdef FEAT_ARB_RR_EN
  logic rr_q, rr_d;  // 1: requester 1 wins the next tie

  assign win1 = req1 & (~req0 | rr_q);

  always_comb begin
    rr_d = rr_q;
    if (state_q == IDLE && any_req) rr_d = ~win1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_q <= 1'b0;
    else     rr_q <= rr_d;
  end
`else
  assign win1 = req1 & ~req0;
`endif

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    cnt_d      = cnt_q;
    gnt_d      = 2'b00;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d    = win1 ? BURST1 : BURST0;
          cur_addr_d = win1 ? base1[ADDR_W-1:0] : base0[ADDR_W-1:0];
          cnt_d      = win1 ? len1 : len0;
          gnt_d      = {win1, ~win1};
        end
      end
      BURST0, BURST1: begin
        // len 0 wraps through all-ones and still ends at 1, giving 2^LEN_W beats.
        cur_addr_d = cur_addr_q + ADDR_W'(1);
        cnt_d      = cnt_q - LEN_W'(1);
        if (last_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Return side trails the RAM request by the RAM's one-cycle read latency.
  assign rvalid_d = {state_q == BURST1, state_q == BURST0};
  assign done_d   = rvalid_d & {2{last_beat}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      cnt_q      <= '0;
      gnt_q      <= 2'b00;
      rvalid_q   <= 2'b00;
      done_q     <= 2'b00;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign ram_en   = busy;
  assign ram_addr = busy ? cur_addr_q : '0;
  assign rdata    = ram_dout;

  assign gnt0    = gnt_q[0];
  assign gnt1    = gnt_q[1];
  assign rvalid0 = rvalid_q[0];
  assign rvalid1 = rvalid_q[1];
  assign done0   = done_q[0];
  assign done1   = done_q[1];

endmodule

// File: tb/tb_feature_rd_arbiter.sv
// Bench for feature_rd_arbiter: directed vector table, reset/tie sequences and random bursts
// checked against a burst-level model (RAM word k holds k+1).
module tb_feature_rd_arbiter;
  localparam int AW = 5, DW = 128, LW = 5;
  localparam int DEPTH = 1 << AW;
  localparam int MAXLEN = 1 << LW;

  logic clk = 1'b0;
  logic rst;
  logic req0, req1;
  logic [15:0] base0, base1;
  logic [LW-1:0] len0, len1;
  logic gnt0, gnt1, rvalid0, rvalid1, done0, done1, ram_en, busy;
  logic [DW-1:0] rdata, ram_dout;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] mem [DEPTH];

  int n_vec = 0, n_err = 0;
  bit rr_fav = 1'b0;  // model: requester favoured on a tie

  feature_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .base0(base0), .base1(base1),
    .len0(len0), .len1(len1), .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .done0(done0), .done1(done1), .rdata(rdata), .ram_en(ram_en), .ram_addr(ram_addr),
    .ram_dout(ram_dout), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) if (ram_en) ram_dout <= mem[ram_addr];

  typedef struct {
    bit r0, r1;
    logic [15:0] b0, b1;
    logic [LW-1:0] l0, l1, la;
    int ewin, ebeats;
    logic [DW-1:0] efirst, elast;
  } vec_t;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int model_win(input bit r0, input bit r1);
`ifdef FEAT_ARB_RR_EN
    if (r0 && r1) return int'(rr_fav);
`endif
    return r0 ? 0 : 1;
  endfunction

  function automatic void model_grant(input int w);
    rr_fav = (w == 0);
  endfunction

  task automatic run_burst(input bit r0, input bit r1, input logic [15:0] b0, input logic [15:0] b1,
                           input logic [LW-1:0] l0, input logic [LW-1:0] l1, input logic [LW-1:0] la,
                           output int win, output int beats,
                           output logic [DW-1:0] first, output logic [DW-1:0] last);
    int ew, exp_beats, b;
    bit got, fin;
    ew = model_win(r0, r1);
    exp_beats = ((ew == 1 ? l1 : l0) == 0) ? MAXLEN : int'(ew == 1 ? l1 : l0);
    b = int'(ew == 1 ? b1 : b0) % DEPTH;
    win = -1; beats = 0; first = '0; last = '0;
    @(negedge clk);
    req0 = r0; req1 = r1; base0 = b0; base1 = b1; len0 = l0; len1 = l1;
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (gnt0 | gnt1) got = 1;
    end
    chk("gnt_seen", DW'(got), 1);
    if (!got) begin
      req0 = 0; req1 = 0;
      return;
    end
    win = gnt1 ? 1 : 0;
    chk("gnt_owner", DW'(win), DW'(ew));
    chk("gnt_both", DW'(gnt0 & gnt1), 0);
    chk("ram_addr_first", DW'(ram_addr), DW'(b));
    model_grant(ew);
    // Requests and burst fields change after the grant; the burst must ignore them.
    req0 = 0; req1 = 0; base0 = ~b0; base1 = ~b1; len0 = la; len1 = la;
    @(negedge clk);
    chk("gnt_pulse", DW'({gnt0, gnt1}), 0);
    fin = 0;
    for (int i = 0; i < MAXLEN + 8 && !fin; i++) begin
      if ((done0 | done1) && !(rvalid0 | rvalid1)) begin
        chk("done_without_rvalid", 1, 0);
        fin = 1;
      end else if (rvalid0 | rvalid1) begin
        chk("rvalid_both", DW'(rvalid0 & rvalid1), 0);
        chk("rvalid_owner", DW'(rvalid1), DW'(win));
        chk("rdata", rdata, DW'(((b + beats) % DEPTH) + 1));
        if (beats == 0) first = rdata;
        last = rdata;
        beats++;
        if (done0 | done1) begin
          chk("done_owner", DW'(done1), DW'(win));
          chk("done_beat", DW'(beats), DW'(exp_beats));
          chk("busy_after_done", DW'(busy), 0);
          fin = 1;
        end
      end
      if (!fin) @(negedge clk);
    end
    if (!fin) chk("done_seen", 0, 1);
  endtask

  vec_t tv [6];
  int w, nb;
  logic [DW-1:0] f, l;

  initial begin
    for (int k = 0; k < DEPTH; k++) mem[k] = DW'(k + 1);
    rst = 1; req0 = 0; req1 = 0; base0 = 0; base1 = 0; len0 = 0; len1 = 0;
    tv[0] = '{1, 0, 16'd0,     16'd7,     5'd4, 5'd3, 5'd9,  0, 4,  1,  4};
    tv[1] = '{0, 1, 16'd3,     16'd30,    5'd7, 5'd4, 5'd2,  1, 4,  31, 2};
    tv[2] = '{1, 0, 16'd0,     16'd9,     5'd0, 5'd5, 5'd3,  0, 32, 1,  32};
    tv[3] = '{0, 1, 16'd2,     16'hFFFF,  5'd2, 5'd1, 5'd6,  1, 1,  32, 32};
    tv[4] = '{0, 1, 16'd1,     16'h0025,  5'd1, 5'd3, 5'd0,  1, 3,  6,  8};
    tv[5] = '{1, 0, 16'd31,    16'd4,     5'd2, 5'd8, 5'd17, 0, 2,  32, 1};

    @(negedge clk); @(negedge clk);
    chk("reset_outs", DW'({gnt0, gnt1, rvalid0, rvalid1, done0, done1, ram_en, busy}), 0);
    chk("reset_addr", DW'(ram_addr), 0);
    rst = 0;

    foreach (tv[i]) begin
      run_burst(tv[i].r0, tv[i].r1, tv[i].b0, tv[i].b1, tv[i].l0, tv[i].l1, tv[i].la, w, nb, f, l);
      chk($sformatf("vec%0d_win", i), DW'(w), DW'(tv[i].ewin));
      chk($sformatf("vec%0d_beats", i), DW'(nb), DW'(tv[i].ebeats));
      chk($sformatf("vec%0d_first", i), f, tv[i].efirst);
      chk($sformatf("vec%0d_last", i), l, tv[i].elast);
    end

    // Both requesters held with len 2: grant order follows the arbitration policy.
    begin
      int ng, ew;
      bit prev_busy;
      @(negedge clk);
      req0 = 1; req1 = 1; base0 = 0; base1 = 16; len0 = 2; len1 = 2;
      ng = 0; prev_busy = 0;
      for (int i = 0; i < 40 && ng < 3; i++) begin
        @(negedge clk);
        chk("tie_rvalid_both", DW'(rvalid0 & rvalid1), 0);
        if (gnt0 | gnt1) begin
          ew = model_win(1, 1);
          model_grant(ew);
          chk($sformatf("tie_gnt%0d_owner", ng), DW'(gnt1), DW'(ew));
          if (ng > 0) chk("tie_idle_gap", DW'(prev_busy), 0);
          ng++;
          if (ng == 3) begin req0 = 0; req1 = 0; end
        end
        prev_busy = busy;
      end
      chk("tie_grants", DW'(ng), 3);
      req0 = 0; req1 = 0;
      for (int i = 0; i < 6; i++) @(negedge clk);
    end

    // Reset on the second beat of a len 8 burst.
    begin
      bit got;
      int junk;
      @(negedge clk);
      req0 = 1; base0 = 4; len0 = 8;
      got = 0;
      for (int i = 0; i < 8 && !got; i++) begin
        @(negedge clk);
        if (gnt0) got = 1;
      end
      chk("rst_seq_gnt", DW'(got), 1);
      req0 = 0;
      @(negedge clk);
      rst = 1;
      #1;
      chk("rst_mid_outs", DW'({gnt0, gnt1, rvalid0, rvalid1, done0, done1, ram_en, busy}), 0);
      chk("rst_mid_addr", DW'(ram_addr), 0);
      rr_fav = 0;
      @(negedge clk); @(negedge clk);
      rst = 0;
      junk = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (rvalid0 | rvalid1 | done0 | done1 | busy | ram_en) junk++;
      end
      chk("rst_no_residue", DW'(junk), 0);
      run_burst(1, 0, 16'd8, 16'd0, 5'd3, 5'd0, 5'd1, w, nb, f, l);
      chk("post_rst_beats", DW'(nb), 3);
      chk("post_rst_first", f, 9);
    end

    for (int i = 0; i < 30; i++) begin
      bit r0, r1;
      r0 = 1'($urandom_range(0, 1));
      r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
      run_burst(r0, r1, 16'($urandom), 16'($urandom), LW'($urandom), LW'($urandom), LW'($urandom),
                w, nb, f, l);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/feature_rd_arbiter.md
FEATURE_RD_ARBITER -- requirements
Module: feature_rd_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 5: feature RAM address width; the RAM holds 2^ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 128: feature word width.
REQ-003 SHALL have parameter LEN_W, default 5: burst length field width.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have ports req0 / req1, input, 1 each: level burst request; 0 = accelerator, 1 = ARM readback.
REQ-007 SHALL have ports base0 / base1, input, 16 each: burst start address; only bits [ADDR_W-1:0] are used.
REQ-008 SHALL have ports len0 / len1, input, LEN_W each: beat count; 0 encodes 2^LEN_W.
REQ-009 SHALL have ports gnt0 / gnt1, output, 1 each: one-cycle pulse; the burst is accepted.
REQ-010 SHALL have ports rvalid0 / rvalid1, output, 1 each: rdata is valid for that requester this cycle.
REQ-011 SHALL have ports done0 / done1, output, 1 each: one-cycle pulse on the last rvalid of the burst.
REQ-012 SHALL have port rdata, output, DATA_W: shared return data, driven straight from ram_dout.
REQ-013 SHALL have ports ram_en, output, 1 and ram_addr, output, ADDR_W: feature RAM read port enable and address.
REQ-014 SHALL have port ram_dout, input, DATA_W: RAM read data, registered inside the RAM, valid one cycle after ram_en.
REQ-015 SHALL have port busy, output, 1: state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, BURST0 and BURST1.
REQ-017 In IDLE with any request pending, the arbiter SHALL select a winner per REQ-030/031 and, at the clock edge, load cur_addr=base[ADDR_W-1:0] and cnt=len from the winner and enter BURSTx.
REQ-018 gnt_x SHALL be registered and high for exactly the first cycle of BURSTx.
REQ-019 In BURSTx the arbiter SHALL drive ram_en=1 and ram_addr=cur_addr every cycle, increment cur_addr modulo 2^ADDR_W, and decrement cnt.
REQ-020 On the beat where cnt==1 (or the final beat of a len=0 burst), the FSM SHALL return to IDLE; a new grant therefore has at least one idle cycle between bursts.
REQ-021 rvalid_x SHALL be registered as ram_en delayed one cycle, tagged with the owner of that beat; read latency from ram_en to rvalid is 1 cycle.
REQ-022 done_x SHALL be registered and coincide with the final rvalid_x of the burst.
REQ-023 rvalid0 and rvalid1 SHALL never both be high in the same cycle.
REQ-024 Address wrap SHALL be silent, e.g. base=2^ADDR_W-1 continues at 0.
REQ-025 Deasserting req during a burst SHALL NOT abort the burst; req is sampled only in IDLE.
REQ-026 base and len SHALL be sampled only at the grant edge; later changes SHALL NOT affect the active burst.
REQ-027 ram_en SHALL be 0 in IDLE.

Reset
REQ-028 While rst is high, the arbiter SHALL force state=IDLE; gnt*, rvalid*, done*, ram_en and busy to 0; ram_addr, cur_addr and cnt to 0; and the round-robin pointer to favour requester 0.
REQ-029 Reset mid-burst SHALL discard the in-flight beat, with no rvalid or done following the release of rst.

Configuration
REQ-030 With FEAT_ARB_RR_EN defined, arbitration SHALL be round-robin: on a tie, the requester not granted last wins; the pointer updates on each grant.
REQ-031 Without FEAT_ARB_RR_EN, arbitration SHALL be fixed priority, with requester 0 always winning a tie and no pointer register present.

Verification
REQ-032 RAM preloaded word k = k+1, req0=1, base0=0, len0=4 -> gnt0 one cycle; ram_addr 0,1,2,3; rvalid0 for 4 cycles with rdata 1,2,3,4; done0 on the 4th beat.
REQ-033 base1=30, len1=4 -> ram_addr 30,31,0,1; rdata 31,32,1,2.
REQ-034 req0 and req1 both held with len=2 -> RR: grants alternate 0,1,0; fixed priority: only gnt0, and req1 starves while req0 is held.
REQ-035 len0=0 -> 32 beats, addresses 0..31, done0 on beat 32.
REQ-036 rst asserted on the 2nd beat of a len=8 burst -> all outputs 0 immediately; no rvalid/done after release; the next request is granted normally.
REQ-037 len0 changed from 4 to 9 one cycle after gnt0 -> still exactly 4 beats.
